// File: rtl/conv1d_pkg.sv
// conv1d_pkg: shared sizes, output word record and config clamp helpers for the
// conv1d output stage.
package conv1d_pkg;

  localparam int unsigned BYTE_SIZE    = 8;
  localparam int unsigned INT32_SIZE   = 32;
  localparam int unsigned MAX_CHANNELS = 128;
  localparam int unsigned MAX_POOL     = 4;

  // Widths able to hold the clamped config values themselves (1..MAX).
  localparam int unsigned CH_W   = $clog2(MAX_CHANNELS + 1);
  localparam int unsigned POOL_W = $clog2(MAX_POOL + 1);
  localparam int unsigned IDX_W  = $clog2(MAX_CHANNELS);

  typedef struct packed {
    logic [INT32_SIZE-1:0] data;
    logic [2:0]            bytes;
    logic                  last;
  } out_word_t;

  function automatic logic [CH_W-1:0] clamp_depth(input logic [31:0] v);
    if (v == 32'd0) return CH_W'(1);
    if (v > MAX_CHANNELS) return CH_W'(MAX_CHANNELS);
    return v[CH_W-1:0];
  endfunction

  function automatic logic [POOL_W-1:0] clamp_pool(input logic [31:0] v);
    if (v == 32'd0) return POOL_W'(1);
    if (v > MAX_POOL) return POOL_W'(MAX_POOL);
    return v[POOL_W-1:0];
  endfunction

endpackage

// File: rtl/conv1d_out_fifo.sv
// conv1d_out_fifo: synchronous FIFO of out_word_t.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_clr             synchronous flush
//   i_push, i_wdata   write side (caller never pushes when full)
//   i_pop             pop request, ignored when empty
//   o_rdata, o_valid  head entry (zero when empty), head valid
//   o_full            no free entry
module conv1d_out_fifo
  import conv1d_pkg::*;
#(
  parameter int unsigned DEPTH = 4  // power of 2, >= 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_clr,
  input  logic      i_push,
  input  out_word_t i_wdata,
  input  logic      i_pop,
  output out_word_t o_rdata,
  output logic      o_valid,
  output logic      o_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  out_word_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = i_pop && o_valid;
  assign o_rdata = o_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (i_push && !i_clr) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/conv1d_out_pool.sv
// conv1d_out_pool: optional 1-D max-pool along x per channel over an int8
// stream (x-major, channel-minor), packing results little-endian into 32-bit
// words queued in a small FIFO.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   i_cfg_load                     latch depth/pool, flush all state
//   i_cfg_depth, i_cfg_pool        channels per x position, pool window
//   i_in_valid/o_in_ready/i_in_data  int8 input stream
//   o_out_valid/i_out_ready        output word handshake
//   o_out_data/o_out_bytes/o_out_last  packed word, valid byte count, end of position
//   o_pos_count                    pooled positions completed since cfg_load
module conv1d_out_pool
  import conv1d_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cfg_load,
  input  logic [31:0]           i_cfg_depth,
  input  logic [31:0]           i_cfg_pool,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [BYTE_SIZE-1:0]  i_in_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [INT32_SIZE-1:0] o_out_data,
  output logic [2:0]            o_out_bytes,
  output logic                  o_out_last,
  output logic [15:0]           o_pos_count
);

  logic [CH_W-1:0]       r_depth;
  logic [POOL_W-1:0]     r_pool;
  logic [CH_W-1:0]       r_ch;
  logic [POOL_W-1:0]     r_p;
  logic [1:0]            r_lane;
  logic [INT32_SIZE-1:0] r_pack;
  logic [15:0]           r_pos;
  logic [BYTE_SIZE-1:0]  r_max_buf [MAX_CHANNELS];

  logic                  w_accept, w_ch_last, w_p_last, w_res_valid, w_push, w_fifo_full;
  logic [BYTE_SIZE-1:0]  w_buf, w_max, w_res;
  logic [INT32_SIZE-1:0] w_pack_data;
  out_word_t             w_push_word, w_head;

  assign o_in_ready  = !i_cfg_load && !w_fifo_full;
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_ch_last   = (r_ch == r_depth - CH_W'(1));
  assign w_p_last    = (r_p == r_pool - POOL_W'(1));
  assign w_buf       = r_max_buf[r_ch[IDX_W-1:0]];
  assign w_max       = ($signed(w_buf) > $signed(i_in_data)) ? w_buf : i_in_data;
  assign w_res       = (r_pool == POOL_W'(1)) ? i_in_data : w_max;
  assign w_res_valid = w_accept && w_p_last;
  assign w_push      = w_res_valid && ((r_lane == 2'd3) || w_ch_last);

  // Lanes above r_lane are always zero in r_pack, so a short word is zero-padded.
  always_comb begin
    w_pack_data = r_pack;
    w_pack_data[r_lane*BYTE_SIZE +: BYTE_SIZE] = w_res;
  end

  assign w_push_word = '{data: w_pack_data, bytes: {1'b0, r_lane} + 3'd1, last: w_ch_last};

  // Running max is deliberately not reset; phase 0 overwrites it.
  always_ff @(posedge clk) begin
    if (w_accept && !w_p_last) begin
      r_max_buf[r_ch[IDX_W-1:0]] <= (r_p == '0) ? i_in_data : w_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_depth <= CH_W'(1);
      r_pool  <= POOL_W'(1);
      r_ch    <= '0;
      r_p     <= '0;
      r_lane  <= '0;
      r_pack  <= '0;
      r_pos   <= '0;
    end else if (i_cfg_load) begin
      r_depth <= clamp_depth(i_cfg_depth);
      r_pool  <= clamp_pool(i_cfg_pool);
      r_ch    <= '0;
      r_p     <= '0;
      r_lane  <= '0;
      r_pack  <= '0;
      r_pos   <= '0;
    end else if (w_accept) begin
      if (w_ch_last) begin
        r_ch <= '0;
        r_p  <= w_p_last ? '0 : r_p + POOL_W'(1);
      end else begin
        r_ch <= r_ch + CH_W'(1);
      end
      if (w_push) begin
        r_lane <= '0;
        r_pack <= '0;
        if (w_ch_last) r_pos <= r_pos + 16'd1;
      end else if (w_res_valid) begin
        r_lane <= r_lane + 2'd1;
        r_pack <= w_pack_data;
      end
    end
  end

  conv1d_out_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (i_cfg_load),
    .i_push  (w_push),
    .i_wdata (w_push_word),
    .i_pop   (i_out_ready),
    .o_rdata (w_head),
    .o_valid (o_out_valid),
    .o_full  (w_fifo_full)
  );

  assign o_out_data  = w_head.data;
  assign o_out_bytes = w_head.bytes;
  assign o_out_last  = w_head.last;
  assign o_pos_count = r_pos;

endmodule

// File: tb/tb_conv1d_out_pool.sv
module tb_conv1d_out_pool;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cfg_load;
  logic [31:0] i_cfg_depth;
  logic [31:0] i_cfg_pool;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [7:0]  i_in_data;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [31:0] o_out_data;
  logic [2:0]  o_out_bytes;
  logic        o_out_last;
  logic [15:0] o_pos_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  conv1d_out_pool dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cfg_load  (i_cfg_load),
    .i_cfg_depth (i_cfg_depth),
    .i_cfg_pool  (i_cfg_pool),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data),
    .o_out_bytes (o_out_bytes),
    .o_out_last  (o_out_last),
    .o_pos_count (o_pos_count)
  );

  typedef struct {
    int              depth;
    int              pool;
    int              n_in;
    logic [7:0][7:0] din;     // byte i = input i
    int              quiet;   // out_valid must stay 0 after each of the first `quiet` bytes
    int              n_words;
    logic [1:0][31:0] wdata;
    logic [1:0][2:0]  wbytes;
    logic [1:0]       wlast;
    int              pos;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int depth, input int pool);
    i_cfg_depth = depth;
    i_cfg_pool  = pool;
    i_cfg_load  = 1'b1;
    #1;
    chk("in_ready low during cfg_load", {31'd0, o_in_ready}, 32'd0);
    step();
    i_cfg_load = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b);
    i_in_valid = 1'b1;
    i_in_data  = b;
    step();
    i_in_valid = 1'b0;
  endtask

  task automatic pop_word(input string tag, input logic [31:0] d, input logic [2:0] nb,
                          input logic l);
    chk({tag, " out_valid"}, {31'd0, o_out_valid}, 32'd1);
    chk({tag, " out_data"}, o_out_data, d);
    chk({tag, " out_bytes"}, {29'd0, o_out_bytes}, {29'd0, nb});
    chk({tag, " out_last"}, {31'd0, o_out_last}, {31'd0, l});
    i_out_ready = 1'b1;
    step();
    i_out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_cfg_load = 1'b0; i_cfg_depth = '0; i_cfg_pool = '0;
    i_in_valid = 1'b0; i_in_data = '0; i_out_ready = 1'b0;

    //           depth pool n  inputs                  quiet nw words                            bytes            last   pos
    vecs[0] = '{4, 1, 4, 64'h0000_0000_0403_0201, 3, 1, {32'h0, 32'h0403_0201}, {3'd0, 3'd4}, 2'b01, 1};
    vecs[1] = '{3, 2, 6, 64'h0000_80FF_027F_FD05, 5, 1, {32'h0, 32'h007F_FF05}, {3'd0, 3'd3}, 2'b01, 1};
    vecs[2] = '{6, 1, 6, 64'h0000_0605_0403_0201, 3, 2, {32'h0000_0605, 32'h0403_0201},
                {3'd2, 3'd4}, 2'b10, 1};
    vecs[3] = '{2, 3, 6, 64'h0000_14FA_03F9_0AFB, 5, 1, {32'h0, 32'h0000_14FB}, {3'd0, 3'd2}, 2'b01, 1};
    vecs[4] = '{0, 0, 2, 64'h0000_0000_0000_2211, 0, 2, {32'h22, 32'h11}, {3'd1, 3'd1}, 2'b11, 2};
    vecs[5] = '{1, 9, 4, 64'h0000_0000_0107_FE03, 3, 1, {32'h0, 32'h07}, {3'd0, 3'd1}, 2'b01, 1};

    #12;
    chk("reset out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("reset out_data", o_out_data, 32'd0);
    chk("reset out_bytes", {29'd0, o_out_bytes}, 32'd0);
    chk("reset out_last", {31'd0, o_out_last}, 32'd0);
    chk("reset pos_count", {16'd0, o_pos_count}, 32'd0);
    chk("reset in_ready", {31'd0, o_in_ready}, 32'd1);
    #5 rst_n = 1'b1;
    step();

    for (int v = 0; v < 6; v++) begin
      cfg(vecs[v].depth, vecs[v].pool);
      for (int i = 0; i < vecs[v].n_in; i++) begin
        feed(vecs[v].din[i]);
        if (i < vecs[v].quiet)
          chk($sformatf("vec%0d quiet after byte %0d", v, i), {31'd0, o_out_valid}, 32'd0);
      end
      for (int w = 0; w < vecs[v].n_words; w++)
        pop_word($sformatf("vec%0d word%0d", v, w), vecs[v].wdata[w], vecs[v].wbytes[w],
                 vecs[v].wlast[w]);
      chk($sformatf("vec%0d drained", v), {31'd0, o_out_valid}, 32'd0);
      chk($sformatf("vec%0d pos_count", v), {16'd0, o_pos_count}, vecs[v].pos);
    end

    // Backpressure: 16 bytes fill four words, then the FIFO is full.
    cfg(4, 1);
    for (int i = 1; i <= 16; i++) begin
      feed(8'(i));
      if (i == 15) chk("bp in_ready after 15", {31'd0, o_in_ready}, 32'd1);
    end
    chk("bp in_ready after 16", {31'd0, o_in_ready}, 32'd0);
    step();
    step();
    chk("bp in_ready held low", {31'd0, o_in_ready}, 32'd0);
    pop_word("bp word0", 32'h0403_0201, 3'd4, 1'b1);
    pop_word("bp word1", 32'h0807_0605, 3'd4, 1'b1);
    pop_word("bp word2", 32'h0C0B_0A09, 3'd4, 1'b1);
    pop_word("bp word3", 32'h100F_0E0D, 3'd4, 1'b1);
    chk("bp in_ready returns", {31'd0, o_in_ready}, 32'd1);
    for (int i = 17; i <= 20; i++) feed(8'(i));
    pop_word("bp word4", 32'h1413_1211, 3'd4, 1'b1);
    chk("bp pos_count", {16'd0, o_pos_count}, 32'd5);

    // cfg_load mid-row discards the queued word and the partial bytes.
    cfg(4, 1);
    for (int i = 1; i <= 6; i++) feed(8'(i));
    chk("cl queued before", {31'd0, o_out_valid}, 32'd1);
    cfg(4, 1);
    chk("cl out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("cl pos_count", {16'd0, o_pos_count}, 32'd0);
    for (int i = 7; i <= 10; i++) feed(8'(i));
    pop_word("cl word", 32'h0A09_0807, 3'd4, 1'b1);
    chk("cl empty", {31'd0, o_out_valid}, 32'd0);

    // Asynchronous reset between edges, then reset-default depth=1 pool=1.
    cfg(4, 1);
    for (int i = 1; i <= 4; i++) feed(8'(i));
    chk("ar pending", {31'd0, o_out_valid}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("ar pos_count", {16'd0, o_pos_count}, 32'd0);
    chk("ar in_ready", {31'd0, o_in_ready}, 32'd1);
    #2 rst_n = 1'b1;
    step();
    feed(8'h80);
    pop_word("ar word", 32'h0000_0080, 3'd1, 1'b1);
    chk("ar final pos_count", {16'd0, o_pos_count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv1d_out_pool.md
Name: conv1d_out_pool

Overview:
Downstream stage of the conv1d compute block. It consumes the stream of quantised int8 results in x-major, channel-minor order and applies an optional 1-D max-pool along x per channel. It packs the pooled bytes little-endian into 32-bit words and buffers them in a small FIFO, so the CPU can read 4 results per transfer. This matches the 4-bytes-at-a-time buffer access already used for input/filter writes.

Parameters:
MAX_CHANNELS, 128, maximum output depth (size of running-max buffer)
MAX_POOL, 4, maximum pool window along x
FIFO_DEPTH, 4, output word FIFO entries (power of 2)
BYTE_SIZE, 8, element width
INT32_SIZE, 32, word width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_load  in  1  pulse: latch cfg_depth/cfg_pool, clear all state
cfg_depth  in  32  channels per x position
cfg_pool  in  32  pool window
in_valid  in  1  in_data valid
in_ready  out  1  stage can accept in_data
in_data  in  8  signed int8 quantised result
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer pops head
out_data  out  32  packed word, byte0 in [7:0]
out_bytes  out  3  valid bytes in out_data (1..4)
out_last  out  1  word ends a pooled x position
pos_count  out  16  completed pooled positions since cfg_load (wraps)

Behaviour:
- Clocking and reset: one clock `clk`; reset is asynchronous, active-low, on `rst_n`.
- Reset values: out_valid=0, out_data=0, out_bytes=0, out_last=0, pos_count=0, in_ready=1. Effective depth=1, pool=1. All counters, the packer and the FIFO are empty. The max buffer is not cleared.
- Config clamping: depth 0 is treated as 1; depth >MAX_CHANNELS is clamped to MAX_CHANNELS. Pool 0 is treated as 1; pool >MAX_POOL is clamped to MAX_POOL.
- cfg_load:
  - Takes effect on the next edge and has priority over everything else.
  - Clears channel counter ch, pool phase p, packer, FIFO and pos_count.
  - in_ready=0 during the cfg_load cycle; no input is accepted that cycle.
  - Any pending partial word and all FIFO contents are discarded.
- Handshake: input is accepted when in_valid && in_ready. in_ready = !cfg_load && (fifo_count < FIFO_DEPTH). This is conservative: no skid logic, and no push is ever dropped.
- Pool phase p (0..pool-1) and channel counter ch (0..depth-1), per accepted byte v:
  - p==0 and pool>1: max_buf[ch] <= v.
  - 0<p<pool-1: max_buf[ch] <= signed max(max_buf[ch], v).
  - p==pool-1: result r = signed max(max_buf[ch], v), or r = v when pool==1. r goes to the packer.
  - ch increments; when ch==depth-1, ch wraps to 0 and p increments. When p==pool-1, p wraps to 0.
- max_buf: MAX_CHANNELS x 8 storage, combinational read, one write per cycle.
- Packer: byte lane k = 0..3 fills [8k+7:8k].
  - A word is pushed when lane 3 fills, or when r is for ch==depth-1 (end of position). End-of-position pushes set last=1.
  - Unused upper lanes are zero; bytes = number of filled lanes.
  - At end of position, pos_count increments on the same edge as the push.
- Latency: the accepted byte that completes a word produces out_valid=1 on the next cycle if the FIFO was empty.
- FIFO:
  - Stores {data, bytes, last}; head is registered.
  - Pop on out_valid && out_ready. Simultaneous push and pop is allowed; count is unchanged.
  - Pop when empty is ignored.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. Partial data is lost.
- Arithmetic: all comparisons are signed 8-bit; no widening.

Decomposition:
- Package conv1d_pkg: BYTE_SIZE, INT32_SIZE, MAX_CHANNELS, MAX_POOL.
- Package conv1d_pkg: typedef out_word_t {data[31:0], bytes[2:0], last}.
- One sub-module: conv1d_out_fifo (parameterised sync FIFO of out_word_t, async active-low reset). Pool/pack logic stays in the top module.

Test Plan:
- Pass-through: cfg depth=4 pool=1; inputs 1,2,3,4 -> one word 0x04030201, bytes=4, last=1, pos_count=1.
- Pooling: depth=3 pool=2; x0: 5,-3,127; x1: 2,-1,-128 -> 0x007FFF05, bytes=3, last=1, pos_count=1, nothing emitted after x0.
- Split positions: depth=6 pool=1; inputs 1..6 -> 0x04030201 (bytes=4, last=0) then 0x00000605 (bytes=2, last=1).
- Backpressure: depth=4 pool=1, out_ready=0, stream 20 bytes:
  - in_ready drops after the 16th byte; 4 words are held.
  - Raise out_ready -> words popped in order, in_ready returns, remaining 4 bytes emerge as the 5th word.
- cfg_load mid-row: depth=4 pool=1, feed 2 bytes plus 1 queued word, pulse cfg_load -> FIFO empty, out_valid=0, pos_count=0, partial bytes never output.
- Async reset: assert rst_n low between clock edges mid-stream -> out_valid=0 immediately. After release, depth=1 pool=1: input 0x80 -> word 0x00000080, bytes=1, last=1.
